// File: rtl/locked_sec_pipe.sv
// Key-locked SEC pipeline: keyed XOR gates around a Hamming syndrome decoder,
// plus a serial key loader that drains in-flight words before reloading.
module locked_sec_pipe #(
  parameter int DW = 32,
  parameter int CW = 6,
  parameter int KI = 16,
  parameter int KO = 16,
  parameter logic [KI+KO-1:0] KEY_CONST = 32'hA5A5_0F0F,
  parameter logic [3:0] LUT_CONST = 4'b0110
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_start,
  input  logic          key_bit,
  input  logic          key_bit_valid,
  output logic          key_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] din,
  input  logic [CW-1:0] chk_in,
  input  logic          corr_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dout,
  output logic          se_flag,
  output logic          ce_flag,
  output logic          ue_flag,
  output logic [15:0]   err_cnt,
  output logic [15:0]   ue_cnt
);
  localparam int KT = KI + KO + 4;
  localparam int NW = $clog2(KT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, ARMED} state_e;

  if (KI > DW || KO > DW ||
      (2 ** CW) < DW + CW + 1 ||
      LUT_CONST != 4'b0110) begin : g_bad_cfg
    $error("locked_sec_pipe: unsupported parameters");
  end

  // j-th integer >= 3 that is not a power of two
  function automatic logic [CW-1:0] pos_of(input int j);
    int c;
    logic [CW-1:0] r;
    c = 0;
    r = '0;
    for (int n = 3; n < 2 ** CW; n++) begin
      if ((n & (n - 1)) != 0) begin
        if (c == j) r = CW'(n);
        c++;
      end
    end
    return r;
  endfunction

  state_e state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [KT-1:0] key_q, key_d;
  logic [KI-1:0] kin;
  logic [KO-1:0] kout;
  logic [3:0] lut;

  logic v1_q, c1_q, v2_q;
  logic [DW-1:0] g1_q, dout_q;
  logic [CW-1:0] s1_q;
  logic se_q, ce_q, ue_q;
  logic [15:0] err_q, uec_q;

  logic adv, acc;
  logic [DW-1:0] din_g, dc, flip, dout_d;
  logic [CW-1:0] x, s_in, pa, pb;
  logic se_d, ce_d, ue_d;

  assign kin  = key_q[KI-1:0];
  assign kout = key_q[KI+KO-1:KI];
  assign lut  = key_q[KT-1:KT-4];

  assign adv = !v2_q || out_ready;
  assign in_ready = adv &&
    (state_q == IDLE || state_q == ARMED);
  assign acc = in_valid && in_ready;
  assign key_ready = state_q == ARMED;

  always_comb begin
    din_g = din;
    x = '0;
    pa = '0;
    for (int k = 0; k < KI; k++)
      din_g[k] = din[k] ^ kin[k] ^ KEY_CONST[k];
    for (int j = 0; j < DW; j++) begin
      pa = pos_of(j);
      for (int i = 0; i < CW; i++)
        if (pa[i]) x[i] = x[i] ^ din_g[j];
    end
    s_in = chk_in ^ x;
    // bit 0 goes through the keyed LUT instead of a plain XOR
    s_in[0] = lut[{chk_in[0], x[0]}];
  end

  always_comb begin
    dc = g1_q;
    flip = '0;
    pb = '0;
    se_d = 1'b0;
    ce_d = 1'b0;
    ue_d = 1'b0;
    for (int j = 0; j < DW; j++) begin
      pb = pos_of(j);
      flip[j] = (s1_q == pb);
    end
    if (c1_q && s1_q != '0) begin
      unique case (1'b1)
        ((s1_q & (s1_q - CW'(1))) == '0):
          ce_d = 1'b1;
        (|flip): begin
          dc = g1_q ^ flip;
          se_d = 1'b1;
        end
        default: ue_d = 1'b1;
      endcase
    end
    dout_d = dc;
    for (int k = 0; k < KO; k++)
      dout_d[k] = dc[k] ^ kout[k] ^ KEY_CONST[KI+k];
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    key_d = key_q;
    unique case (state_q)
      IDLE, ARMED:
        if (key_start) state_d = DRAIN;
      DRAIN:
        if (!v1_q && !v2_q) begin
          state_d = LOAD;
          cnt_d = '0;
        end
      LOAD:
        if (key_bit_valid) begin
          key_d = {key_bit, key_q[KT-1:1]};
          cnt_d = cnt_q + NW'(1);
          if (cnt_q == NW'(KT - 1))
            state_d = ARMED;
        end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      c1_q <= 1'b0;
      g1_q <= '0;
      s1_q <= '0;
      v2_q <= 1'b0;
      dout_q <= '0;
      se_q <= 1'b0;
      ce_q <= 1'b0;
      ue_q <= 1'b0;
      err_q <= '0;
      uec_q <= '0;
    end else begin
      if (adv) begin
        v1_q <= acc;
        if (acc) begin
          g1_q <= din_g;
          s1_q <= s_in;
          c1_q <= corr_en;
        end
        v2_q <= v1_q;
        if (v1_q) begin
          dout_q <= dout_d;
          se_q <= se_d;
          ce_q <= ce_d;
          ue_q <= ue_d;
        end
      end
      if (v2_q && out_ready) begin
        if (se_q && err_q != 16'hFFFF)
          err_q <= err_q + 16'd1;
        if (ue_q && uec_q != 16'hFFFF)
          uec_q <= uec_q + 16'd1;
      end
    end
  end

  assign out_valid = v2_q;
  assign dout = dout_q;
  assign se_flag = se_q;
  assign ce_flag = ce_q;
  assign ue_flag = ue_q;
  assign err_cnt = err_q;
  assign ue_cnt = uec_q;
endmodule

// File: tb/tb_locked_sec_pipe.sv
// Directed + randomized bench for locked_sec_pipe with a
// position-list reference decoder and an in-order scoreboard.
module tb_locked_sec_pipe;
  localparam logic [31:0] KEYC = 32'hA5A5_0F0F;
  localparam logic [35:0] GOOD = {4'b0110, KEYC};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_start = 1'b0, key_bit = 1'b0;
  logic key_bit_valid = 1'b0, key_ready;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] din = '0, dout;
  logic [5:0] chk_in = '0;
  logic corr_en = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic se_flag, ce_flag, ue_flag;
  logic [15:0] err_cnt, ue_cnt;

  int checks = 0, passed = 0;
  int exp_err = 0, exp_ue = 0;
  logic [35:0] bkey = '0;
  logic [34:0] q[$];

  always #5 clk = ~clk;

  locked_sec_pipe #(
    .DW(32), .CW(6), .KI(16), .KO(16),
    .KEY_CONST(KEYC), .LUT_CONST(4'b0110)
  ) dut (
    .clk(clk), .rst(rst),
    .key_start(key_start), .key_bit(key_bit),
    .key_bit_valid(key_bit_valid),
    .key_ready(key_ready),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .chk_in(chk_in), .corr_en(corr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .se_flag(se_flag),
    .ce_flag(ce_flag), .ue_flag(ue_flag),
    .err_cnt(err_cnt), .ue_cnt(ue_cnt)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  // Reference: codeword positions listed, syndrome = XOR of set positions
  function automatic logic [34:0] model(
    input logic [35:0] k, input logic [31:0] d,
    input logic [5:0] c, input logic en);
    logic [31:0] g, dc, o;
    int pos[32];
    int n, sd, s, hit;
    logic [3:0] lut;
    logic se, ce, ue;
    lut = k[35:32];
    g = d ^ {16'h0, k[15:0] ^ KEYC[15:0]};
    n = 3;
    sd = 0;
    for (int j = 0; j < 32; j++) begin
      while ((n & (n - 1)) == 0) n++;
      pos[j] = n;
      if (g[j]) sd = sd ^ n;
      n++;
    end
    s = ((int'(c) ^ sd) & 32'h3E) |
        int'(lut[2 * int'(c[0]) + (sd & 1)]);
    dc = g;
    se = 0; ce = 0; ue = 0;
    if (en && s != 0) begin
      if ((s & (s - 1)) == 0) ce = 1;
      else begin
        hit = -1;
        for (int j = 0; j < 32; j++)
          if (pos[j] == s) hit = j;
        if (hit >= 0) begin
          dc[hit] = ~dc[hit];
          se = 1;
        end else ue = 1;
      end
    end
    o = dc ^ {16'h0, k[31:16] ^ KEYC[31:16]};
    return {o, se, ce, ue};
  endfunction

  task automatic check(input string tag,
    input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
      tag, obs, exp);
  endtask

  function automatic logic [34:0] outs();
    return {dout, se_flag, ce_flag, ue_flag};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; key_start = 0;
    key_bit_valid = 0; out_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    exp_err = 0; exp_ue = 0; bkey = '0;
    q.delete();
  endtask

  task automatic load_key(input logic [35:0] k);
    @(negedge clk) key_start = 1;
    @(negedge clk) key_start = 0;
    @(negedge clk);
    for (int i = 0; i < 36; i++) begin
      key_bit = k[i];
      key_bit_valid = 1;
      @(negedge clk);
    end
    key_bit_valid = 0;
    bkey = k;
    check("key_ready", key_ready, 1);
  endtask

  task automatic run_word(input string tag,
    input logic [31:0] d, input logic [5:0] c,
    input logic en, input logic [34:0] exp);
    logic [34:0] m;
    @(negedge clk);
    out_ready = 1; in_valid = 1;
    din = d; chk_in = c; corr_en = en;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk) in_valid = 0;
    check({tag, "_lat1"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, outs(), exp);
    m = model(bkey, d, c, en);
    exp_err += int'(m[2]);
    exp_ue += int'(m[0]);
    @(negedge clk);
  endtask

  task automatic run_random(input int n);
    logic prev_stall;
    logic [34:0] prev, e, obs;
    prev_stall = 0;
    prev = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      in_valid = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      din = $urandom;
      chk_in = 6'($urandom);
      corr_en = ($urandom % 5) != 0;
      #1;
      obs = outs();
      if (prev_stall)
        check("hold", {out_valid, obs}, {1'b1, prev});
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious", out_valid, 0);
        else begin
          e = q.pop_front();
          check("rand_out", obs, e);
          exp_err += int'(e[2]);
          exp_ue += int'(e[0]);
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(bkey, din, chk_in, corr_en));
      prev_stall = out_valid && !out_ready;
      prev = obs;
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        check("rand_tail", outs(), e);
        exp_err += int'(e[2]);
        exp_ue += int'(e[0]);
      end
      @(negedge clk);
    end
    check("rand_drained", q.size(), 0);
    check("rand_err_cnt", err_cnt, exp_err);
    check("rand_ue_cnt", ue_cnt, exp_ue);
  endtask

  initial begin
    logic [31:0] w[3];
    int acc_n, got, bad;
    do_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outs", outs(), 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_ue_cnt", ue_cnt, 0);
    check("rst_key_ready", key_ready, 0);
    check("rst_in_ready", in_ready, 1);

    load_key(GOOD);
    run_word("zero", 0, 0, 1, {32'h0, 3'b000});
    run_word("se", 1, 0, 1, {32'h0, 3'b100});
    check("err_cnt_1", err_cnt, 1);
    run_word("ue", 0, 6'h3F, 1, {32'h0, 3'b001});
    check("ue_cnt_1", ue_cnt, 1);
    run_word("ce", 0, 6'h01, 1, {32'h0, 3'b010});
    run_word("bypass", 1, 0, 0, {32'h1, 3'b000});
    load_key({4'b0000, KEYC});
    run_word("lut0", 1, 0, 1, {32'h1, 3'b010});
    load_key(GOOD);

    for (int i = 0; i < 3; i++) w[i] = $urandom;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 0; in_valid = 1;
      din = w[acc_n > 2 ? 2 : acc_n];
      chk_in = 0; corr_en = 0;
      #1 if (in_ready) acc_n++;
    end
    @(negedge clk) in_valid = 0;
    #1;
    check("stall_accepted", acc_n, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_valid", out_valid, 1);
    check("stall_dout", dout, w[0]);
    @(negedge clk);
    check("stall_dout_held", dout, w[0]);
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      out_ready = 1;
      in_valid = acc_n < 3;
      din = w[acc_n < 3 ? acc_n : 0];
      #1;
      if (in_valid && in_ready) acc_n++;
      if (out_valid) begin
        check("stall_order", dout, w[got]);
        got++;
      end
    end
    in_valid = 0;
    check("stall_count", got, 3);
    @(negedge clk);
    @(negedge clk);
    check("stall_no_dup", out_valid, 0);

    @(negedge clk);
    out_ready = 0; in_valid = 1;
    din = $urandom; corr_en = 0;
    @(negedge clk) din = $urandom;
    @(negedge clk) in_valid = 0;
    key_start = 1;
    @(negedge clk) key_start = 0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      key_bit_valid = 1; key_bit = 1;
      #1 if (in_ready || key_ready || !out_valid) bad++;
      @(negedge clk);
    end
    key_bit_valid = 0;
    check("drain_hold", bad, 0);
    out_ready = 1;
    for (int c = 0; c < 10 && out_valid; c++)
      @(negedge clk);
    check("drain_empty", out_valid, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      key_bit = 1'($urandom) | 1'(i == 0);
      key_bit_valid = 1;
      @(negedge clk);
    end
    key_bit_valid = 0;
    do_reset();
    #1;
    check("mid_rst_key_ready", key_ready, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_err_cnt", err_cnt, 0);
    run_word("zero_key", 0, 0, 1, model('0, 0, 0, 1));
    din = $urandom;
    run_word("zero_key_r", din, 6'h15, 1,
      model('0, din, 6'h15, 1));

    load_key({4'($urandom), $urandom});
    run_random(400);
    load_key(GOOD);
    run_random(400);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
